rx_destuff: RTL and testbench

RX_DESTUFF -- requirements
Module: rx_destuff

---
 rtl/rx_destuff_if.sv | 25 ++
 rtl/rx_destuff.sv | 115 +++++++++++
 tb/tb_rx_destuff.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_destuff_if.sv
// Bit-level handshake between the bus sampler and the receive destuffer.
// The sampler side (master) drives bits and control; the destuffer (slave) returns data and status.
interface rx_destuff_if #(
   parameter int SCNT_W = 8
);
   logic              bitin;
   logic              sample;
   logic              en;
   logic              clr;
   logic              bitout;
   logic              bitvalid;
   logic              stuffbit;
   logic              stufferr;
   logic [SCNT_W-1:0] stuffcnt;

   modport master (
      output bitin, sample, en, clr,
      input  bitout, bitvalid, stuffbit, stufferr, stuffcnt
   );

   modport slave (
      input  bitin, sample, en, clr,
      output bitout, bitvalid, stuffbit, stufferr, stuffcnt
   );
endinterface

// File: rtl/rx_destuff.sv
// Receive bit destuffer: removes the complementary bit inserted after STUFF_LEN equal bits,
// flags a run of STUFF_LEN+1 equal bits as a sticky stuff error and counts removed stuff bits.
module rx_destuff #(
   parameter int STUFF_LEN = 5,
   parameter int SCNT_W    = 8
) (
   input logic          clock,
   input logic          reset,
   rx_destuff_if.slave  bus
);
   localparam int              RUN_W    = $clog2(STUFF_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(STUFF_LEN);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] COUNT  = 2'd1;
   localparam logic [1:0] EXPECT = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic [RUN_W-1:0]  run_q,      run_d;
   logic              runbit_q,   runbit_d;
   logic              bitout_q,   bitout_d;
   logic              bitvalid_q, bitvalid_d;
   logic              stuffbit_q, stuffbit_d;
   logic              stufferr_q, stufferr_d;
   logic [SCNT_W-1:0] stuffcnt_q, stuffcnt_d;

   // NOTE: combinational logic uses blocking '=' and every output gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      runbit_d   = runbit_q;
      bitout_d   = bitout_q;
      bitvalid_d = 1'b0;
      stuffbit_d = 1'b0;
      stufferr_d = stufferr_q;
      stuffcnt_d = stuffcnt_q;

      if (bus.clr) begin
         // A coincident sample is dropped on purpose.
         state_d    = IDLE;
         run_d      = '0;
         stufferr_d = 1'b0;
         stuffcnt_d = '0;
      end else if (state_q == ERROR) begin
         state_d = ERROR;
      end else if (!bus.en) begin
         state_d = IDLE;
         run_d   = '0;
         if (bus.sample) begin
            bitvalid_d = 1'b1;
            bitout_d   = bus.bitin;
         end
      end else if (bus.sample) begin
         case (state_q)
            IDLE, COUNT: begin
               bitvalid_d = 1'b1;
               bitout_d   = bus.bitin;
               if (state_q == COUNT && bus.bitin == runbit_q) begin
                  run_d = run_q + RUN_ONE;
               end else begin
                  runbit_d = bus.bitin;
                  run_d    = RUN_ONE;
               end
               state_d = (run_d == RUN_FULL) ? EXPECT : COUNT;
            end
            EXPECT: begin
               if (bus.bitin != runbit_q) begin
                  // The stuff bit itself opens the next run.
                  stuffbit_d = 1'b1;
                  if (stuffcnt_q != '1)
                     stuffcnt_d = stuffcnt_q + SCNT_W'(1);
                  runbit_d = bus.bitin;
                  run_d    = RUN_ONE;
                  state_d  = (RUN_ONE == RUN_FULL) ? EXPECT : COUNT;
               end else begin
                  stufferr_d = 1'b1;
                  state_d    = ERROR;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         run_q      <= '0;
         runbit_q   <= 1'b1;
         bitout_q   <= 1'b1;
         bitvalid_q <= 1'b0;
         stuffbit_q <= 1'b0;
         stufferr_q <= 1'b0;
         stuffcnt_q <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         runbit_q   <= runbit_d;
         bitout_q   <= bitout_d;
         bitvalid_q <= bitvalid_d;
         stuffbit_q <= stuffbit_d;
         stufferr_q <= stufferr_d;
         stuffcnt_q <= stuffcnt_d;
      end
   end

   assign bus.bitout   = bitout_q;
   assign bus.bitvalid = bitvalid_q;
   assign bus.stuffbit = stuffbit_q;
   assign bus.stufferr = stufferr_q;
   assign bus.stuffcnt = stuffcnt_q;
endmodule

// File: tb/tb_rx_destuff.sv
// Scenario bench for rx_destuff: each sent bit queues its expected pulse, a monitor pops and
// compares pulses (kind, bitout, cycle) as the DUT produces them.
module tb_rx_destuff;
   localparam int SCNT_W = 8;

   typedef enum {K_DATA, K_STUFF, K_NONE} kind_e;
   typedef struct {
      bit   stuff;
      logic val;
      int   due;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   rx_destuff_if #(.SCNT_W(SCNT_W)) bus ();
   rx_destuff #(.STUFF_LEN(5), .SCNT_W(SCNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic last_out = 1'b1;

   always @(posedge clock) cyc = cyc + 1;

   // Monitor: pulses appear exactly one cycle after their sample.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         if (bus.bitvalid && bus.stuffbit) begin
            checks++; errors++;
            $display("FAIL pulse_exclusive cycle %0d: bitvalid and stuffbit both high", cyc);
         end
         if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL missing_pulse cycle %0d: got none, required stuff=%0d due cycle %0d",
                     cyc, sb[0].stuff, sb[0].due);
            void'(sb.pop_front());
         end
         if (bus.bitvalid || bus.stuffbit) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse cycle %0d: got bitvalid=%0d stuffbit=%0d, required none",
                        cyc, bus.bitvalid, bus.stuffbit);
            end else begin
               e = sb.pop_front();
               if (bus.stuffbit !== e.stuff || bus.bitout !== e.val || cyc != e.due) begin
                  errors++;
                  $display("FAIL pulse cycle %0d: got stuff=%0d bitout=%0d, required stuff=%0d bitout=%0d at cycle %0d",
                           cyc, bus.stuffbit, bus.bitout, e.stuff, e.val, e.due);
               end
            end
         end
      end
   end

   task automatic send(input logic b, input kind_e k);
      exp_t e;
      @(negedge clock);
      bus.sample = 1'b1;
      bus.bitin  = b;
      if (k == K_DATA) last_out = b;
      if (k != K_NONE) begin
         e.stuff = (k == K_STUFF);
         e.val   = last_out;
         e.due   = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clock);
      bus.sample = 1'b0;
   endtask

   task automatic send_run(input logic b, input int n, input kind_e k);
      for (int i = 0; i < n; i++) send(b, k);
   endtask

   task automatic pulse_clr();
      @(negedge clock);
      bus.clr = 1'b1;
      @(negedge clock);
      bus.clr = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (bus.bitout !== 1'b1 || bus.bitvalid !== 1'b0 || bus.stuffbit !== 1'b0 ||
          bus.stufferr !== 1'b0 || bus.stuffcnt !== '0) begin
         errors++;
         $display("FAIL reset_values: got bitout=%0d bitvalid=%0d stuffbit=%0d stufferr=%0d stuffcnt=%0d, required 1 0 0 0 0",
                  bus.bitout, bus.bitvalid, bus.stuffbit, bus.stufferr, bus.stuffcnt);
      end
      reset = 1'b1;
      last_out = 1'b1;
   endtask

   task automatic test_v1_single_stuff();
      bus.en = 1'b1;
      send_run(1'b0, 5, K_DATA);
      send(1'b1, K_STUFF);
      send(1'b0, K_DATA);
      settle();
      checks++;
      if (bus.stuffcnt !== 8'd1 || bus.stufferr !== 1'b0) begin
         errors++;
         $display("FAIL v1_status: got stuffcnt=%0d stufferr=%0d, required 1 0", bus.stuffcnt, bus.stufferr);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL v1_drain: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_v2_stuff_error();
      pulse_clr();
      bus.en = 1'b1;
      send_run(1'b1, 5, K_DATA);
      checks++;
      if (bus.stufferr !== 1'b0) begin
         errors++;
         $display("FAIL v2_no_early_err: got stufferr=%0d, required 0", bus.stufferr);
      end
      send(1'b1, K_NONE);
      checks++;
      if (bus.stufferr !== 1'b1) begin
         errors++;
         $display("FAIL v2_err_set: got stufferr=%0d, required 1", bus.stufferr);
      end
      send(1'b0, K_NONE);
      send(1'b1, K_NONE);
      bus.en = 1'b0;
      send(1'b0, K_NONE);
      settle();
      checks++;
      if (bus.stufferr !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL v2_err_sticky: got stufferr=%0d pending=%0d, required 1 0", bus.stufferr, sb.size());
      end
   endtask

   task automatic test_v3_clr_recover();
      pulse_clr();
      checks++;
      if (bus.stufferr !== 1'b0 || bus.stuffcnt !== '0) begin
         errors++;
         $display("FAIL v3_clr: got stufferr=%0d stuffcnt=%0d, required 0 0", bus.stufferr, bus.stuffcnt);
      end
      bus.en = 1'b1;
      send(1'b1, K_DATA);
      send(1'b0, K_DATA);
      settle();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL v3_drain: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_v4_passthrough();
      bus.en = 1'b0;
      send_run(1'b1, 8, K_DATA);
      settle();
      checks++;
      if (bus.stufferr !== 1'b0 || bus.stuffcnt !== '0 || sb.size() != 0) begin
         errors++;
         $display("FAIL v4_status: got stufferr=%0d stuffcnt=%0d pending=%0d, required 0 0 0",
                  bus.stufferr, bus.stuffcnt, sb.size());
      end
   endtask

   task automatic test_v5_back_to_back();
      pulse_clr();
      bus.en = 1'b1;
      send_run(1'b0, 5, K_DATA);
      send(1'b1, K_STUFF);
      send_run(1'b1, 4, K_DATA);
      send(1'b0, K_STUFF);
      settle();
      checks++;
      if (bus.stuffcnt !== 8'd2 || bus.stufferr !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL v5_status: got stuffcnt=%0d stufferr=%0d pending=%0d, required 2 0 0",
                  bus.stuffcnt, bus.stufferr, sb.size());
      end
   endtask

   task automatic test_v6_mid_reset();
      send_run(1'b0, 3, K_DATA);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.bitout !== 1'b1 || bus.bitvalid !== 1'b0 || bus.stuffbit !== 1'b0 ||
          bus.stufferr !== 1'b0 || bus.stuffcnt !== '0) begin
         errors++;
         $display("FAIL v6_async_reset: got bitout=%0d bitvalid=%0d stuffbit=%0d stufferr=%0d stuffcnt=%0d, required 1 0 0 0 0",
                  bus.bitout, bus.bitvalid, bus.stuffbit, bus.stufferr, bus.stuffcnt);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (bus.bitout !== 1'b1 || bus.stuffcnt !== '0) begin
         errors++;
         $display("FAIL v6_reset_hold: got bitout=%0d stuffcnt=%0d, required 1 0", bus.bitout, bus.stuffcnt);
      end
      reset = 1'b1;
      last_out = 1'b1;
      send_run(1'b0, 5, K_DATA);
      send(1'b1, K_STUFF);
      settle();
      checks++;
      if (bus.stuffcnt !== 8'd1 || bus.stufferr !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL v6_status: got stuffcnt=%0d stufferr=%0d pending=%0d, required 1 0 0",
                  bus.stuffcnt, bus.stufferr, sb.size());
      end
   endtask

   task automatic test_en_drop();
      pulse_clr();
      bus.en = 1'b1;
      send_run(1'b1, 4, K_DATA);
      bus.en = 1'b0;
      send(1'b1, K_DATA);
      bus.en = 1'b1;
      send_run(1'b1, 5, K_DATA);
      @(negedge clock);
      bus.en = 1'b0;
      @(negedge clock);
      bus.en = 1'b1;
      send_run(1'b1, 5, K_DATA);
      send(1'b0, K_STUFF);
      settle();
      checks++;
      if (bus.stuffcnt !== 8'd1 || bus.stufferr !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL en_drop_status: got stuffcnt=%0d stufferr=%0d pending=%0d, required 1 0 0",
                  bus.stuffcnt, bus.stufferr, sb.size());
      end
   endtask

   task automatic test_clr_priority();
      bus.en = 1'b1;
      send_run(1'b0, 3, K_DATA);
      @(negedge clock);
      bus.clr    = 1'b1;
      bus.sample = 1'b1;
      bus.bitin  = 1'b0;
      @(negedge clock);
      bus.clr    = 1'b0;
      bus.sample = 1'b0;
      checks++;
      if (bus.stuffcnt !== '0 || bus.bitvalid !== 1'b0) begin
         errors++;
         $display("FAIL clr_priority: got stuffcnt=%0d bitvalid=%0d, required 0 0", bus.stuffcnt, bus.bitvalid);
      end
      send_run(1'b0, 5, K_DATA);
      send(1'b1, K_STUFF);
      settle();
      checks++;
      if (bus.stuffcnt !== 8'd1 || sb.size() != 0) begin
         errors++;
         $display("FAIL clr_restart: got stuffcnt=%0d pending=%0d, required 1 0", bus.stuffcnt, sb.size());
      end
   endtask

   task automatic test_saturation();
      logic b;
      pulse_clr();
      bus.en = 1'b1;
      b = 1'b0;
      send_run(b, 5, K_DATA);
      for (int i = 0; i < 300; i++) begin
         b = ~b;
         send(b, K_STUFF);
         send_run(b, 4, K_DATA);
         if (i == 254) begin
            checks++;
            if (bus.stuffcnt !== 8'd255) begin
               errors++;
               $display("FAIL sat_reach: got stuffcnt=%0d, required 255", bus.stuffcnt);
            end
         end
      end
      settle();
      checks++;
      if (bus.stuffcnt !== 8'd255 || bus.stufferr !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL sat_hold: got stuffcnt=%0d stufferr=%0d pending=%0d, required 255 0 0",
                  bus.stuffcnt, bus.stufferr, sb.size());
      end
   endtask

   initial begin
      bus.sample = 1'b0;
      bus.bitin  = 1'b1;
      bus.en     = 1'b0;
      bus.clr    = 1'b0;
      test_reset();
      test_v1_single_stuff();
      test_v2_stuff_error();
      test_v3_clr_recover();
      test_v4_passthrough();
      test_v5_back_to_back();
      test_v6_mid_reset();
      test_en_drop();
      test_clr_priority();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "time limit");
   end
endmodule
